// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one half-duplex RS485 uart_tx between NUM_REQ frame sources.
//   A round-robin arbiter grants one whole frame at a time. The frame bytes
//   are read through a shared byte port with one-cycle read latency and are
//   handed to uart_tx one byte at a time. Every frame, including a rejected
//   one, is followed by an idle guard period so the bus can turn around.
// Ports
//   CLK, reset      clock; asynchronous active-high reset
//   req_i           per-source frame request, held until frame_done/frame_err
//   req_len_i       per-source frame length, 6 bits each, sampled at grant
//   byte_data_i     per-source byte, 8 bits each, valid 1 cycle after byte_addr_o
//   byte_addr_o     index of the byte being read from the granted source
//   grant_o         one-hot registered grant, zero when idle
//   frame_done_o    1-cycle pulse when the frame of source i has been sent
//   frame_err_o     1-cycle pulse when the frame of source i is rejected/aborted
//   tx_transmit_o   1-cycle start pulse to uart_tx
//   tx_data_o       byte to uart_tx, stable from tx_transmit_o until tx_done_i
//   tx_active_i     uart_tx busy
//   tx_done_i       uart_tx byte-complete pulse
//   busy_o          high whenever the arbiter is not idle
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int MAX_LEN      = 32,
  parameter int GUARD_CYCLES = 16,
  parameter int TX_TIMEOUT   = 4096
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [6*NUM_REQ-1:0] req_len_i,
  input  logic [8*NUM_REQ-1:0] byte_data_i,
  output logic [5:0]           byte_addr_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [NUM_REQ-1:0]   frame_done_o,
  output logic [NUM_REQ-1:0]   frame_err_o,
  output logic                 tx_transmit_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_active_i,
  input  logic                 tx_done_i,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GUARD     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [5:0]         len_q, len_d;
  logic [5:0]         byte_addr_q, byte_addr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] frame_done_q, frame_done_d;
  logic [NUM_REQ-1:0] frame_err_q, frame_err_d;
  logic               tx_transmit_q, tx_transmit_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [GW-1:0]      guard_q, guard_d;

  logic               win_found_s;
  logic [IW-1:0]      win_idx_s;
  logic [IW-1:0]      rr_next_s;
  logic [5:0]         win_len_s;
  logic [NUM_REQ-1:0] win_onehot_s;
  logic [NUM_REQ-1:0] sel_onehot_s;
  logic [7:0]         sel_byte_s;
  logic               sel_req_s;

  // Round-robin winner: lowest requesting index at or above rr_q, otherwise
  // wrap to the lowest requesting index overall. The second loop overrides
  // the first only when a candidate at or above the pointer exists.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win_found_s = req_i[i] ? 1'b1 : win_found_s;
      win_idx_s   = req_i[i] ? IW'(i) : win_idx_s;
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      win_idx_s = (req_i[i] && (IW'(i) >= rr_q)) ? IW'(i) : win_idx_s;
    end
    rr_next_s    = (win_idx_s == IW'(NUM_REQ - 1)) ? '0 : (win_idx_s + IW'(1));
    win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
    sel_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_q;
  end

  // Per-source field selection for the winner and for the granted source.
  always_comb begin
    win_len_s  = 6'd0;
    sel_byte_s = 8'd0;
    sel_req_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_len_s  = (win_idx_s == IW'(i)) ? req_len_i[6*i +: 6]   : win_len_s;
      sel_byte_s = (sel_q == IW'(i))     ? byte_data_i[8*i +: 8] : sel_byte_s;
      sel_req_s  = (sel_q == IW'(i))     ? req_i[i]              : sel_req_s;
    end
  end

  // Next-state and registered-output logic of the frame sequencer.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    sel_d         = sel_q;
    len_d         = len_q;
    byte_addr_d   = byte_addr_q;
    grant_d       = grant_q;
    frame_done_d  = '0;
    frame_err_d   = '0;
    tx_transmit_d = 1'b0;
    tx_data_d     = tx_data_q;
    tmo_d         = tmo_q;
    guard_d       = guard_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          rr_d = rr_next_s;
          if ((win_len_s == 6'd0) || (win_len_s > 6'(MAX_LEN))) begin
            // Rejected length still consumes a turn and a guard period.
            frame_err_d = win_onehot_s;
            guard_d     = '0;
            state_d     = S_GUARD;
          end else begin
            grant_d     = win_onehot_s;
            sel_d       = win_idx_s;
            len_d       = win_len_s;
            byte_addr_d = 6'd0;
            state_d     = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        // Never start a byte while the transmitter still reports busy.
        if (!tx_active_i) begin
          tx_data_d     = sel_byte_s;
          tx_transmit_d = 1'b1;
          tmo_d         = '0;
          state_d       = S_WAIT_DONE;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done_i) begin
          if (byte_addr_q == (len_q - 6'd1)) begin
            frame_done_d = sel_onehot_s;
            grant_d      = '0;
            guard_d      = '0;
            state_d      = S_GUARD;
          end else if (!sel_req_s) begin
            frame_err_d = sel_onehot_s;
            grant_d     = '0;
            guard_d     = '0;
            state_d     = S_GUARD;
          end else begin
            byte_addr_d = byte_addr_q + 6'd1;
            state_d     = S_FETCH;
          end
        end else if (tmo_q == TW'(TX_TIMEOUT - 1)) begin
          frame_err_d = sel_onehot_s;
          grant_d     = '0;
          guard_d     = '0;
          state_d     = S_GUARD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GUARD: begin
        if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without pulses.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      sel_q         <= '0;
      len_q         <= 6'd0;
      byte_addr_q   <= 6'd0;
      grant_q       <= '0;
      frame_done_q  <= '0;
      frame_err_q   <= '0;
      tx_transmit_q <= 1'b0;
      tx_data_q     <= 8'd0;
      tmo_q         <= '0;
      guard_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      sel_q         <= sel_d;
      len_q         <= len_d;
      byte_addr_q   <= byte_addr_d;
      grant_q       <= grant_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      tx_transmit_q <= tx_transmit_d;
      tx_data_q     <= tx_data_d;
      tmo_q         <= tmo_d;
      guard_q       <= guard_d;
    end
  end

  assign byte_addr_o   = byte_addr_q;
  assign grant_o       = grant_q;
  assign frame_done_o  = frame_done_q;
  assign frame_err_o   = frame_err_q;
  assign tx_transmit_o = tx_transmit_q;
  assign tx_data_o     = tx_data_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 10-cycle uart_tx model, a byte
// source whose byte for source i at address a is i*32+a, and monitors that
// log grants, transmitted bytes and timing for the directed steps below.
module tb_uart_tx_arbiter;
  localparam int NR  = 3;
  localparam int ML  = 32;
  localparam int GC  = 16;
  localparam int TMO = 256;
  localparam int UC  = 10;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_i = '0;
  logic [6*NR-1:0] req_len_i = '0;
  logic [8*NR-1:0] byte_data_i = '0;
  logic [5:0]      byte_addr_o;
  logic [NR-1:0]   grant_o, frame_done_o, frame_err_o;
  logic            tx_transmit_o;
  logic [7:0]      tx_data_o;
  logic            tx_active_i = 1'b0;
  logic            tx_done_i = 1'b0;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  logic [NR-1:0] drop_mask = '0;
  logic          uart_hang = 1'b0;
  int            stx = 0;

  int            cyc = 0, rise_cyc = 0, fall_cyc = 0;
  logic          have_fall = 1'b0, first_pend = 1'b0;
  logic [NR-1:0] prev_grant = '0;
  int            n_tx = 0, viol = 0, overlap = 0;
  int            n_done [NR];
  int            n_err  [NR];
  int            gorder[$];
  logic [7:0]    txlog[$];
  int            gaps[$];
  int            lat_log[$];
  int            sp_log[$];
  int            ucyc = 0, ucnt = 0, done_cyc = 0;
  logic          done_pend = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .GUARD_CYCLES(GC), .TX_TIMEOUT(TMO)) dut (
    .CLK(CLK), .reset(reset), .req_i(req_i), .req_len_i(req_len_i),
    .byte_data_i(byte_data_i), .byte_addr_o(byte_addr_o), .grant_o(grant_o),
    .frame_done_o(frame_done_o), .frame_err_o(frame_err_o),
    .tx_transmit_o(tx_transmit_o), .tx_data_o(tx_data_o),
    .tx_active_i(tx_active_i), .tx_done_i(tx_done_i), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  // Byte source memory, answered well inside the one-cycle read latency.
  always @(negedge CLK) begin
    for (int i = 0; i < NR; i++) byte_data_i[8*i +: 8] = 8'(i*32 + int'(byte_addr_o));
  end

  // uart_tx model: busy for UC cycles per byte, then a tx_done pulse.
  always @(negedge CLK) begin
    ucyc++;
    tx_done_i = 1'b0;
    if (reset) begin
      tx_active_i = 1'b0; ucnt = 0; done_pend = 1'b0;
    end else begin
      if (grant_o == '0) done_pend = 1'b0;
      if (tx_transmit_o) begin
        if (tx_active_i) overlap++;
        if (done_pend) begin sp_log.push_back(ucyc - done_cyc); done_pend = 1'b0; end
        tx_active_i = 1'b1; ucnt = UC;
      end else if (ucnt > 0) begin
        ucnt--;
        if (ucnt == 0) begin
          tx_active_i = 1'b0;
          if (!uart_hang) begin tx_done_i = 1'b1; done_cyc = ucyc; done_pend = 1'b1; end
        end
      end
    end
  end

  // Output monitor: grant order, bytes sent, pulses, guard gaps, latency.
  always @(negedge CLK) begin
    cyc++;
    if (reset) begin
      have_fall = 1'b0; first_pend = 1'b0; prev_grant = '0;
    end else begin
      if (tx_transmit_o) begin
        n_tx++;
        txlog.push_back(tx_data_o);
        if (first_pend) begin lat_log.push_back(cyc - rise_cyc); first_pend = 1'b0; end
      end
      if (prev_grant == '0 && grant_o != '0) begin
        for (int i = 0; i < NR; i++) if (grant_o[i]) gorder.push_back(i);
        if (have_fall) gaps.push_back(cyc - fall_cyc);
        rise_cyc = cyc; first_pend = 1'b1;
      end
      if (prev_grant != '0 && grant_o == '0) begin fall_cyc = cyc; have_fall = 1'b1; end
      for (int i = 0; i < NR; i++) begin
        if (frame_done_o[i]) begin
          n_done[i]++;
          if (!prev_grant[i] || grant_o != '0) viol++;
        end
        if (frame_err_o[i]) n_err[i]++;
      end
      if (frame_done_o != '0 && frame_err_o != '0) viol++;
      if (!$onehot0(grant_o)) viol++;
      prev_grant = grant_o;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no end of test, required $finish before 5 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
    if (tx_transmit_o) stx++;
    req_i = req_i & ~((frame_done_o | frame_err_o) & drop_mask);
  endtask

  task automatic run_idle(input int budget, input string tag);
    int n = 0;
    step(); n++;
    while (!(req_i == '0 && !busy_o) && n < budget) begin step(); n++; end
    chk(tag, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic set_len(input int i, input int l);
    req_len_i[6*i +: 6] = 6'(l);
  endtask

  int lat_seen = 0, sp_seen = 0, gap_seen = 0;
  task automatic check_timing(input string tag);
    for (int i = lat_seen; i < lat_log.size(); i++) chk({tag, "_latency"}, lat_log[i], 32'd2);
    for (int i = sp_seen; i < sp_log.size(); i++) chk({tag, "_byte_spacing"}, sp_log[i], 32'd3);
    for (int i = gap_seen; i < gaps.size(); i++)
      chk({tag, "_guard_gap"}, (gaps[i] >= GC) ? 32'd1 : 32'd0, 32'd1);
    lat_seen = lat_log.size(); sp_seen = sp_log.size(); gap_seen = gaps.size();
  endtask

  initial begin
    int g0, t0, tx0, d0, e0, e1, n, t_tx, t_err;
    for (int i = 0; i < NR; i++) begin n_done[i] = 0; n_err[i] = 0; end

    // Reset state, with all three sources already requesting 2-byte frames.
    for (int i = 0; i < NR; i++) set_len(i, 2);
    req_i = 3'b111; drop_mask = 3'b111;
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx_transmit", tx_transmit_o, 0);
    chk("rst_tx_data", tx_data_o, 0);
    chk("rst_byte_addr", byte_addr_o, 0);
    chk("rst_frame_done", frame_done_o, 0);
    chk("rst_frame_err", frame_err_o, 0);

    // Contention: order 0,1,2 with guard gaps between frames.
    reset = 1'b0;
    run_idle(2000, "contention_timeout");
    chk("cont_ngrant", gorder.size(), 3);
    chk("cont_order0", gorder[0], 0);
    chk("cont_order1", gorder[1], 1);
    chk("cont_order2", gorder[2], 2);
    chk("cont_ntx", n_tx, 6);
    chk("cont_byte0", txlog[0], 8'h00);
    chk("cont_byte1", txlog[1], 8'h01);
    chk("cont_byte2", txlog[2], 8'h20);
    chk("cont_byte3", txlog[3], 8'h21);
    chk("cont_byte4", txlog[4], 8'h40);
    chk("cont_byte5", txlog[5], 8'h41);
    chk("cont_done0", n_done[0], 1);
    chk("cont_done2", n_done[2], 1);
    chk("cont_ngaps", gaps.size(), 2);
    check_timing("cont");

    // Pointer back at 0: sources 0 and 2 -> 0 first.
    g0 = gorder.size();
    set_len(0, 1); set_len(2, 1);
    req_i = 3'b101;
    run_idle(2000, "rrprobe_timeout");
    chk("rr_first", gorder[g0], 0);
    chk("rr_second", gorder[g0+1], 2);
    check_timing("rr");

    // Fairness: both held continuously -> 0,2,0,2.
    g0 = gorder.size();
    drop_mask = 3'b000;
    req_i = 3'b101;
    n = 0;
    while (gorder.size() < g0 + 4 && n < 2000) begin step(); n++; end
    chk("fair_wait", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    req_i = 3'b000;
    run_idle(2000, "fair_timeout");
    chk("fair_order0", gorder[g0], 0);
    chk("fair_order1", gorder[g0+1], 2);
    chk("fair_order2", gorder[g0+2], 0);
    chk("fair_order3", gorder[g0+3], 2);
    check_timing("fair");

    // Single source, 7 bytes.
    drop_mask = 3'b111;
    t0 = txlog.size(); d0 = n_done[0]; e0 = n_err[0];
    set_len(0, 7);
    req_i = 3'b001;
    run_idle(2000, "single_timeout");
    chk("single_ntx", txlog.size() - t0, 7);
    for (int i = 0; i < 7; i++) chk("single_byte", txlog[t0+i], 32'(i));
    chk("single_done", n_done[0] - d0, 1);
    chk("single_err", n_err[0] - e0, 0);
    check_timing("single");

    // Length reject: 0 then 40.
    tx0 = n_tx; g0 = gorder.size(); e1 = n_err[1];
    set_len(1, 0); req_i = 3'b010;
    run_idle(500, "rej0_timeout");
    chk("rej0_err", n_err[1] - e1, 1);
    set_len(1, 40); req_i = 3'b010;
    run_idle(500, "rej40_timeout");
    chk("rej_err_total", n_err[1] - e1, 2);
    chk("rej_ntx", n_tx - tx0, 0);
    chk("rej_no_grant", gorder.size() - g0, 0);

    // Abort: source withdraws while the third of five bytes is in flight.
    tx0 = stx; d0 = n_done[0]; e0 = n_err[0];
    set_len(0, 5); req_i = 3'b001;
    n = 0;
    while (stx < tx0 + 3 && n < 2000) begin step(); n++; end
    chk("abort_wait", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    req_i = 3'b000;
    run_idle(2000, "abort_timeout");
    chk("abort_ntx", stx - tx0, 3);
    chk("abort_err", n_err[0] - e0, 1);
    chk("abort_done", n_done[0] - d0, 0);
    check_timing("abort");

    // Timeout: uart never completes the byte.
    uart_hang = 1'b1;
    e0 = n_err[0]; t_tx = -1; t_err = -1;
    set_len(0, 2); req_i = 3'b001;
    n = 0;
    while (t_err < 0 && n < 2000) begin
      step(); n++;
      if (tx_transmit_o && t_tx < 0) t_tx = n;
      if (frame_err_o[0]) t_err = n;
    end
    chk("tmo_wait", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    chk("tmo_delay", t_err - t_tx, TMO);
    run_idle(500, "tmo_idle_timeout");
    chk("tmo_err", n_err[0] - e0, 1);
    uart_hang = 1'b0;
    check_timing("tmo");

    // Reset while the third byte of a 10-byte frame starts.
    tx0 = stx; d0 = n_done[0]; e0 = n_err[0];
    set_len(0, 10); req_i = 3'b001;
    n = 0;
    while (stx < tx0 + 3 && n < 2000) begin step(); n++; end
    chk("rstmid_wait", (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    reset = 1'b1;
    #1;
    chk("rstmid_grant", grant_o, 0);
    chk("rstmid_tx_transmit", tx_transmit_o, 0);
    chk("rstmid_busy", busy_o, 0);
    req_i = 3'b000;
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    chk("rstmid_no_done", n_done[0] - d0, 0);
    chk("rstmid_no_err", n_err[0] - e0, 0);
    check_timing("rstmid");

    // After reset: pointer 0 again, frame restarts at byte 0.
    g0 = gorder.size(); t0 = txlog.size();
    set_len(0, 1); set_len(2, 1);
    req_i = 3'b101;
    step();
    chk("post_rst_byte_addr", byte_addr_o, 0);
    run_idle(2000, "post_rst_timeout");
    chk("post_rst_first", gorder[g0], 0);
    chk("post_rst_second", gorder[g0+1], 2);
    chk("post_rst_byte", txlog[t0], 8'h00);
    check_timing("post_rst");

    chk("pulse_violations", viol, 0);
    chk("transmit_while_active", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
